// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage definitions: multiply/divide op encodings, MDU state and datapath width.
`timescale 1ns/1ps
package mips_pkg;

  localparam int unsigned WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_addsub.sv
// Combinational 33-bit add/subtract with carry-out, shared by the multiply add step and the
// divide trial subtract.
`timescale 1ns/1ps
module mdu_addsub
  import mips_pkg::*;
(
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] sum_o,
  output logic           cout_o
);

  logic [WIDTH+1:0] full;

  // Subtract as a + ~b + 1; carry-out high means no borrow.
  assign full   = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{(WIDTH+1){1'b0}}, sub_i};
  assign sum_o  = full[WIDTH:0];
  assign cout_o = full[WIDTH+1];

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: one bit per cycle on unsigned magnitudes, sign fix-up at the end,
// results kept in the architectural HI/LO registers.
`timescale 1ns/1ps
module mult_div_unit
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] wrData,
  output logic             busy,
  output logic             done,
  output logic             divZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mdu_state_e         state_q, state_d;
  logic [4:0]         count_q, count_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_pend_q, dz_pend_d;
  logic               div_zero_q, div_zero_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

  logic               s1, s2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     add_a, add_b, add_sum;
  logic               add_cout;
  logic [2*WIDTH-1:0] prod_res;
  logic [WIDTH-1:0]   quot_res, rem_res;

  // op[0] set means unsigned.
  assign s1   = ~op[0] & data1[WIDTH-1];
  assign s2   = ~op[0] & data2[WIDTH-1];
  assign mag1 = s1 ? ('0 - data1) : data1;
  assign mag2 = s2 ? ('0 - data2) : data2;

  // Multiply adds the multiplicand into the upper half when the next multiplier bit is set;
  // divide trial-subtracts the divisor from the remainder with the next dividend bit shifted in.
  always_comb begin
    if (is_div_q) begin
      add_a = acc_q[2*WIDTH-1:WIDTH-1];
      add_b = {1'b0, opnd_q};
    end else begin
      add_a = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
      add_b = acc_q[0] ? {1'b0, opnd_q} : '0;
    end
  end

  mdu_addsub u_addsub (
    .a_i    (add_a),
    .b_i    (add_b),
    .sub_i  (is_div_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign prod_res = neg_q ? ('0 - acc_q) : acc_q;
  assign quot_res = neg_q ? ('0 - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
  assign rem_res  = neg_rem_q ? ('0 - acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    neg_rem_d  = neg_rem_q;
    dz_pend_d  = dz_pend_q;
    div_zero_d = div_zero_q;
    done_d     = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = CALC;
          count_d    = '0;
          div_zero_d = 1'b0;
          is_div_d   = op[1];
          neg_d      = s1 ^ s2;
          neg_rem_d  = s1;
          dz_pend_d  = op[1] & (data2 == '0);
          acc_d      = {{WIDTH{1'b0}}, (op[1] ? mag1 : mag2)};
          opnd_d     = op[1] ? mag2 : mag1;
        end else begin
          if (hiWrite) hi_d = wrData;
          if (loWrite) lo_d = wrData;
        end
      end
      CALC: begin
        if (is_div_q) begin
          acc_d = add_cout ? {add_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                           : {acc_q[2*WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          // A zero divisor leaves the dividend magnitude as remainder, so HI restores data1.
          hi_d = rem_res;
          lo_d = dz_pend_q ? '1 : quot_res;
          div_zero_d = dz_pend_q;
        end else begin
          {hi_d, lo_d} = prod_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_pend_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      neg_rem_q  <= neg_rem_d;
      dz_pend_q  <= dz_pend_d;
      div_zero_q <= div_zero_d;
      done_q     <= done_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign divZero = div_zero_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit; expected HI/LO/divZero come from a 64-bit arithmetic model
// queued at issue time and popped when done pulses.
`timescale 1ns/1ps
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, hiWrite, loWrite;
  logic [1:0]  op;
  logic [31:0] data1, data2, wrData;
  logic        busy, done, divZero;
  logic [31:0] hi, lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   pulses;

  mult_div_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .data1   (data1),
    .data2   (data2),
    .hiWrite (hiWrite),
    .loWrite (loWrite),
    .wrData  (wrData),
    .busy    (busy),
    .done    (done),
    .divZero (divZero),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, sq, sr;
    logic [63:0] ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    e  = '0;
    case (o)
      MDU_MULT: begin
        up = sa * sb;
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      MDU_MULTU: begin
        up = ua * ub;
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dz = 1'b1;
        end else if (o == MDU_DIV) begin
          sq = sa / sb;
          sr = sa % sb;
          e.lo = sq[31:0];
          e.hi = sr[31:0];
        end else begin
          up = ua / ub;
          e.lo = up[31:0];
          up = ua % ub;
          e.hi = up[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Called at a negedge; the request is taken at the following posedge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    data1 = a;
    data2 = b;
    sb_q.push_back(model(o, a, b));
  endtask

  // Waits (bounded) for done, optionally injects a start+MTHI while busy, then scores the result.
  task automatic finish_op(input string tag, input bit chk_busy, input bit inject);
    int   n, nb;
    exp_t e;
    n  = 1;
    nb = 0;
    @(negedge clk);
    start = 1'b0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) nb++;
      if (inject && n == 5) begin
        start   = 1'b1;
        op      = MDU_MULTU;
        data1   = 32'h1234_5678;
        data2   = 32'h0000_0009;
        hiWrite = 1'b1;
        wrData  = 32'hDEAD_BEEF;
      end
      if (inject && n == 6) begin
        start   = 1'b0;
        hiWrite = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 34);
    if (chk_busy) begin
      check({tag, "_busy_cycles"}, nb, 33);
      check({tag, "_busy_in_done"}, 32'(busy), 0);
    end
    n_cmp++;
    assert (sb_q.size() > 0) else begin
      n_err++;
      $error("FAIL %s_scoreboard: observed empty queue expected one entry", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_hi"}, hi, e.hi);
      check({tag, "_lo"}, lo, e.lo);
      check({tag, "_divzero"}, 32'(divZero), 32'(e.dz));
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    hiWrite = 1'b0;
    loWrite = 1'b0;
    op      = 2'b00;
    data1   = '0;
    data2   = '0;
    wrData  = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_divzero", 32'(divZero), 0);
    reset = 1'b0;
    @(negedge clk);

    // MTHI and MTLO together, then MTLO alone
    hiWrite = 1'b1;
    loWrite = 1'b1;
    wrData  = 32'hA5A5_0F0F;
    @(negedge clk);
    hiWrite = 1'b0;
    loWrite = 1'b0;
    wrData  = 32'h5555_AAAA;
    check("mthi_both_hi", hi, 32'hA5A5_0F0F);
    check("mtlo_both_lo", lo, 32'hA5A5_0F0F);
    loWrite = 1'b1;
    wrData  = 32'h0000_0042;
    @(negedge clk);
    loWrite = 1'b0;
    check("mtlo_only_lo", lo, 32'h0000_0042);
    check("mtlo_only_hi", hi, 32'hA5A5_0F0F);

    issue(MDU_MULT, 32'd7, 32'hFFFF_FFFD);
    finish_op("mult_7_m3", 1'b1, 1'b0);
    @(negedge clk);
    check("mult_done_once", 32'(done), 0);

    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 1'b1, 1'b0);
    issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    finish_op("div_m7_2", 1'b1, 1'b0);
    issue(MDU_DIVU, 32'd100, 32'd7);
    finish_op("divu_100_7", 1'b0, 1'b0);
    issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    finish_op("div_ovf", 1'b0, 1'b0);
    issue(MDU_DIVU, 32'd100, 32'd0);
    finish_op("divu_zero", 1'b1, 1'b0);
    // Issued in the done cycle; must be accepted and clear divZero.
    issue(MDU_MULT, 32'd1, 32'd1);
    finish_op("b2b_mult", 1'b1, 1'b0);

    issue(MDU_DIVU, 32'd1000, 32'd3);
    finish_op("robust", 1'b1, 1'b1);
    @(negedge clk);
    check("robust_no_queued_done", 32'(done), 0);
    check("robust_no_queued_busy", 32'(busy), 0);

    // Reset in the middle of CALC
    hiWrite = 1'b1;
    wrData  = 32'h0000_1234;
    @(negedge clk);
    hiWrite = 1'b0;
    check("mthi_1234", hi, 32'h0000_1234);
    start = 1'b1;
    op    = MDU_MULT;
    data1 = 32'd5;
    data2 = 32'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    @(negedge clk);
    reset  = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("midrst_no_done", pulses, 0);
    check("midrst_hi_after", hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the execute stage, beside the ALU. It consumes the same register-file operands (data1, data2) and implements MULT/MULTU/DIV/DIVU into architectural HI/LO registers, plus MTHI/MTLO writes. Results feed write-back through MFHI/MFLO via the hi/lo outputs. While an operation is in flight, `busy` stalls the pipeline control.

## Interface
- WIDTH, 32, operand and HI/LO width; only 32 is supported.
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  one-cycle request; sampled only in IDLE
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- data1  input  32  multiplicand / dividend (rs)
- data2  input  32  multiplier / divisor (rt)
- hiWrite  input  1  MTHI: HI <= wrData
- loWrite  input  1  MTLO: LO <= wrData
- wrData  input  32  MTHI/MTLO data
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when HI/LO have been updated
- divZero  output  1  sticky until next accepted start: last DIV/DIVU had data2 == 0
- hi  output  32  HI register
- lo  output  32  LO register

## Operation
- States: IDLE, CALC, FIX.
- IDLE + start:
  - Latch op and the operand magnitudes. Signed ops negate negative operands; unsigned ops use operands as-is.
  - Record the result signs: product/quotient sign = s1^s2; remainder sign = s1.
  - Clear count and divZero, then go to CALC.
- CALC, one bit per cycle, count 0..31:
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract using a 33-bit subtract.
  - At count==31, go to FIX.
- FIX:
  - Apply the recorded sign negation.
  - Write HI (upper product / remainder) and LO (lower product / quotient).
  - Pulse done and return to IDLE.
- Divide by zero, detected at start:
  - Still runs the full latency.
  - FIX writes HI = data1 (as latched) and LO = 32'hFFFF_FFFF, then sets divZero.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0. No flag.
- start while busy: ignored; no queuing.
- hiWrite/loWrite:
  - Take effect at the next edge only in IDLE with start low.
  - Ignored in CALC/FIX, and ignored when start is high in IDLE (start wins).
  - hiWrite and loWrite together: both applied.
- Reset, asserted in any state:
  - State goes to IDLE.
  - hi, lo, busy, done, divZero, count and the accumulators go to 0 immediately.
  - An in-flight operation is discarded; HI/LO are not updated by it.

## Timing
- Start edge E0 (start high in IDLE): busy = 1 from E0.
- E1..E32: CALC iterations.
- E33: FIX edge.
  - hi/lo hold new values after E33.
  - done = 1 for exactly the cycle after E33.
  - busy = 0 in that same cycle.
- Latency: start accepted → results visible is 33 cycles.
- Back-to-back: a new start may be accepted in the done cycle, since state is IDLE.
- hi/lo are registered outputs; they never change except at FIX, an MTHI/MTLO edge, or reset.
- divZero is valid from the done cycle and cleared at the next accepted start.

## Structure
- Shared package mips_pkg holds:
  - op encodings MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU
  - state typedef {IDLE, CALC, FIX}
  - the WIDTH constant
- The ALU control decoder produces op/start from the same package.
- One natural sub-module: mdu_addsub, a combinational 33-bit add/subtract with carry-out. It is shared by the multiply add step and the divide trial subtract; the FSM and registers stay in mult_div_unit.

## Test plan
- MULT data1=7, data2=0xFFFF_FFFD (−3): after 33 cycles, hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; done pulses once; busy high for exactly 33 cycles.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF: hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV −7/2 (0xFFFF_FFF9, 2): lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100/7: lo=14, hi=2.
- DIVU 100/0: hi=100, lo=0xFFFF_FFFF, divZero=1. Next MULT 1×1 clears divZero to 0.
- Reset asserted at CALC count 10 after MTHI 0x1234: hi=lo=0 immediately and busy=0; no done pulse follows.
- Robustness, same test:
  - start and hiWrite while busy are both ignored: result matches the first op, and HI is not overwritten by wrData.
  - start in the done cycle is accepted.
